// File: rtl/scie_req_arbiter_if.sv
// ---------------------------------------------------------------------------
// scie_req_arbiter_if
//   Requester-side bundle of the SCIE request arbiter.
//   master : requester group (drives valid/lock/insn/operands, sees ready/rsp)
//   slave  : arbiter side
//   req_valid/req_ready/req_lock : NUM_REQ bits, one per requester
//   req_insn/req_rs1/req_rs2     : flattened, requester i at [i*XLEN +: XLEN]
//   rsp_valid                    : one-hot (or zero) result strobe
//   rsp_data                     : result word, zero when no strobe
// ---------------------------------------------------------------------------
interface scie_req_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int XLEN    = 32
);
   logic [NUM_REQ-1:0]      req_valid;
   logic [NUM_REQ-1:0]      req_ready;
   logic [NUM_REQ-1:0]      req_lock;
   logic [NUM_REQ*XLEN-1:0] req_insn;
   logic [NUM_REQ*XLEN-1:0] req_rs1;
   logic [NUM_REQ*XLEN-1:0] req_rs2;
   logic [NUM_REQ-1:0]      rsp_valid;
   logic [XLEN-1:0]         rsp_data;

   modport master (
      output req_valid, req_lock, req_insn, req_rs1, req_rs2,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_lock, req_insn, req_rs1, req_rs2,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/scie_req_arbiter.sv
// ---------------------------------------------------------------------------
// scie_req_arbiter
//   Shares one pipelined custom-instruction unit between NUM_REQ requesters.
//   Round-robin grant per issue, optional lock that keeps the grant across a
//   multi-beat sequence, lock watchdog, and routing of read results back to
//   the issuing requester LATENCY cycles after issue.
// Ports
//   clock, reset    : rising-edge clock, asynchronous active-low reset
//   req             : requester bundle (slave modport)
//   scie_valid      : issue strobe to the unit
//   scie_insn/rs1/rs2 : granted requester's fields, zero when idle
//   scie_rd         : result from the unit
//   lock_timeout    : one-cycle pulse when the watchdog releases a lock
//   dbg_state       : current FSM state (0 = ARB, 1 = LOCKED)
// Handshake: a beat transfers (issues) in a cycle where req_valid[i] and
//   req_ready[i] are both 1. req_ready is combinational from req_valid and
//   never depends on a transfer having happened; at most one bit is set.
//   rsp_valid has no backpressure and is seen for exactly one cycle.
// ---------------------------------------------------------------------------
module scie_req_arbiter #(
   parameter int         NUM_REQ      = 2,
   parameter int         XLEN         = 32,
   parameter int         LATENCY      = 2,
   parameter logic [6:0] RD_OPCODE    = 7'h5B,
   parameter int         LOCK_TIMEOUT = 16
) (
   input  logic                clock,
   input  logic                reset,
   scie_req_arbiter_if.slave   req,
   output logic                scie_valid,
   output logic [XLEN-1:0]     scie_insn,
   output logic [XLEN-1:0]     scie_rs1,
   output logic [XLEN-1:0]     scie_rs2,
   input  logic [XLEN-1:0]     scie_rd,
   output logic                lock_timeout,
   output logic                dbg_state
);

   generate
      if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
         $error("scie_req_arbiter: NUM_REQ must be in 2..8");
      end
      if (LATENCY < 1) begin : g_bad_latency
         $error("scie_req_arbiter: LATENCY must be >= 1");
      end
      if (LOCK_TIMEOUT < 1) begin : g_bad_timeout
         $error("scie_req_arbiter: LOCK_TIMEOUT must be >= 1");
      end
   endgenerate

   localparam int ID_W = $clog2(NUM_REQ);
   localparam int WD_W = $clog2(LOCK_TIMEOUT + 1);

   localparam logic [0:0] ST_ARB    = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   logic [0:0]         state;
   logic [ID_W-1:0]    rr_ptr;
   logic [ID_W-1:0]    owner;
   logic [WD_W-1:0]    watchdog;
   logic [LATENCY-1:0] tag_v;
   logic [ID_W-1:0]    tag_id [LATENCY];

   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    grant_id;
   logic               found;
   logic               issue;
   logic               issue_lock;
   logic               issue_rd;
   logic [ID_W-1:0]    ptr_after;
   int                 cand;

   assign dbg_state = state;

   // Grant search. Masked while reset is asserted so every output shows
   // its reset value even if requesters already hold valid high.
   always_comb begin
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      cand     = 0;
      if (reset) begin
         if (state == ST_LOCKED) begin
            grant_id = owner;
            if (req.req_valid[owner]) begin
               grant[owner] = 1'b1;
            end
         end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
               cand = (int'(rr_ptr) + k) % NUM_REQ;
               if (!found && req.req_valid[cand]) begin
                  found        = 1'b1;
                  grant_id     = ID_W'(cand);
                  grant[cand]  = 1'b1;
               end
            end
         end
      end
   end

   assign issue         = |grant;
   assign req.req_ready = grant;

   assign scie_valid = issue;
   assign scie_insn  = issue ? req.req_insn[int'(grant_id)*XLEN +: XLEN] : '0;
   assign scie_rs1   = issue ? req.req_rs1[int'(grant_id)*XLEN +: XLEN]  : '0;
   assign scie_rs2   = issue ? req.req_rs2[int'(grant_id)*XLEN +: XLEN]  : '0;

   assign issue_lock = issue & req.req_lock[grant_id];
   assign issue_rd   = issue & (scie_insn[6:0] == RD_OPCODE);
   // In LOCKED grant_id is the owner, so this also serves lock release.
   assign ptr_after  = ID_W'((int'(grant_id) + 1) % NUM_REQ);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= ST_ARB;
         rr_ptr       <= '0;
         owner        <= '0;
         watchdog     <= '0;
         lock_timeout <= 1'b0;
      end else begin
         lock_timeout <= 1'b0;
         case (state)
            ST_ARB: begin
               if (issue) begin
                  if (issue_lock) begin
                     state    <= ST_LOCKED;
                     owner    <= grant_id;
                     watchdog <= '0;
                  end else begin
                     rr_ptr <= ptr_after;
                  end
               end
            end
            ST_LOCKED: begin
               if (issue) begin
                  if (issue_lock) begin
                     watchdog <= '0;
                  end else begin
                     state  <= ST_ARB;
                     rr_ptr <= ptr_after;
                  end
               end else if (watchdog == WD_W'(LOCK_TIMEOUT - 1)) begin
                  // Owner went quiet too long: force release, pulse next cycle.
                  state        <= ST_ARB;
                  rr_ptr       <= ptr_after;
                  watchdog     <= '0;
                  lock_timeout <= 1'b1;
               end else begin
                  watchdog <= watchdog + 1'b1;
               end
            end
            default: state <= ST_ARB;
         endcase
      end
   end

   // Tag pipeline: remembers which requester issued each read so the
   // unit's result can be steered back LATENCY cycles later.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tag_v <= '0;
         for (int k = 0; k < LATENCY; k++) begin
            tag_id[k] <= '0;
         end
      end else begin
         tag_v[0]  <= issue_rd;
         tag_id[0] <= grant_id;
         for (int k = 1; k < LATENCY; k++) begin
            tag_v[k]  <= tag_v[k-1];
            tag_id[k] <= tag_id[k-1];
         end
      end
   end

   always_comb begin
      req.rsp_valid = '0;
      req.rsp_data  = '0;
      if (tag_v[LATENCY-1]) begin
         req.rsp_valid[tag_id[LATENCY-1]] = 1'b1;
         req.rsp_data                     = scie_rd;
      end
   end

endmodule

// File: tb/tb_scie_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_scie_req_arbiter
//   Self-checking bench for scie_req_arbiter (NUM_REQ=2, LATENCY=2,
//   LOCK_TIMEOUT=16). Inputs change on the falling edge, outputs are
//   sampled 4 ns later, one ns before the rising edge.
// ---------------------------------------------------------------------------
module tb_scie_req_arbiter;

   localparam int N   = 2;
   localparam int X   = 32;
   localparam int LAT = 2;
   localparam int TO  = 16;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL time_limit: bench did not finish, act=running req=finished");
      $fatal(1, "time limit");
   end

   // ---------------- DUT ----------------
   scie_req_arbiter_if #(.NUM_REQ(N), .XLEN(X)) rif ();

   logic          scie_valid;
   logic [X-1:0]  scie_insn, scie_rs1, scie_rs2, scie_rd;
   logic          lock_timeout;
   logic          dbg_state;

   scie_req_arbiter #(
      .NUM_REQ(N), .XLEN(X), .LATENCY(LAT), .RD_OPCODE(7'h5B), .LOCK_TIMEOUT(TO)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .req          (rif),
      .scie_valid   (scie_valid),
      .scie_insn    (scie_insn),
      .scie_rs1     (scie_rs1),
      .scie_rs2     (scie_rs2),
      .scie_rd      (scie_rd),
      .lock_timeout (lock_timeout),
      .dbg_state    (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] exp_q[$];   // requester id of each outstanding read
   int         due_q[$];   // cycle its result is expected

   // reference model: lock bookkeeping in plain terms
   bit m_locked;
   int m_owner;
   int m_ptr;
   int m_idle;
   bit m_pulse;

   logic [X-1:0] d_insn [N];
   logic [X-1:0] d_rs1  [N];
   logic [X-1:0] d_rs2  [N];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s @cyc %0d: act=0x%0h req=0x%0h", name, cyc, act, req);
      end
   endtask

   task automatic model_reset();
      m_locked = 0; m_owner = 0; m_ptr = 0; m_idle = 0; m_pulse = 0;
      exp_q.delete();
      due_q.delete();
   endtask

   // ---------------- driver + model for one cycle ----------------
   task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] l,
                        input logic [X-1:0] i0, input logic [X-1:0] i1,
                        output logic [N-1:0] a_ready, output logic [N-1:0] a_rsp,
                        output logic a_to);
      int g;
      logic [N-1:0] e_ready, e_rsp;
      logic [X-1:0] e_data;
      @(negedge clock);
      d_insn[0] = i0;  d_insn[1] = i1;
      d_rs1[0]  = $urandom; d_rs1[1] = $urandom;
      d_rs2[0]  = $urandom; d_rs2[1] = $urandom;
      rif.req_valid = v;
      rif.req_lock  = l;
      rif.req_insn  = {d_insn[1], d_insn[0]};
      rif.req_rs1   = {d_rs1[1], d_rs1[0]};
      rif.req_rs2   = {d_rs2[1], d_rs2[0]};
      scie_rd       = $urandom;
      #4;
      a_ready = rif.req_ready;
      a_rsp   = rif.rsp_valid;
      a_to    = lock_timeout;

      // expected response from the outstanding-read list
      e_rsp  = '0;
      e_data = '0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
         e_rsp[exp_q[0]] = 1'b1;
         e_data          = scie_rd;
         void'(exp_q.pop_front());
         void'(due_q.pop_front());
      end

      // expected grant
      g = -1;
      if (m_locked) begin
         if (v[m_owner]) g = m_owner;
      end else begin
         for (int k = 0; k < N; k++) begin
            if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
         end
      end
      e_ready = '0;
      if (g >= 0) e_ready[g] = 1'b1;

      chk("req_ready",    32'(rif.req_ready), 32'(e_ready));
      chk("scie_valid",   32'(scie_valid),    32'(g >= 0));
      chk("scie_insn",    scie_insn,          (g >= 0) ? d_insn[g] : 32'h0);
      chk("scie_rs1",     scie_rs1,           (g >= 0) ? d_rs1[g]  : 32'h0);
      chk("scie_rs2",     scie_rs2,           (g >= 0) ? d_rs2[g]  : 32'h0);
      chk("rsp_valid",    32'(rif.rsp_valid), 32'(e_rsp));
      chk("rsp_data",     rif.rsp_data,       e_data);
      chk("lock_timeout", 32'(lock_timeout),  32'(m_pulse));
      chk("dbg_state",    32'(dbg_state),     32'(m_locked));

      // advance the model to the next cycle
      m_pulse = 0;
      if (g >= 0 && d_insn[g][6:0] == 7'h5B) begin
         exp_q.push_back(8'(g));
         due_q.push_back(cyc + LAT);
      end
      if (!m_locked) begin
         if (g >= 0) begin
            if (l[g]) begin
               m_locked = 1; m_owner = g; m_idle = 0;
            end else begin
               m_ptr = (g + 1) % N;
            end
         end
      end else if (g >= 0) begin
         if (l[g]) m_idle = 0;
         else begin
            m_locked = 0; m_ptr = (m_owner + 1) % N;
         end
      end else begin
         m_idle++;
         if (m_idle == TO) begin
            m_locked = 0; m_ptr = (m_owner + 1) % N; m_idle = 0; m_pulse = 1;
         end
      end
      @(posedge clock);
   endtask

   task automatic do_reset(input int n);
      @(negedge clock);
      reset = 1'b0;
      model_reset();
      rif.req_valid = '1;
      rif.req_lock  = '0;
      rif.req_insn  = {32'h5B, 32'h5B};
      rif.req_rs1   = '1;
      rif.req_rs2   = '1;
      scie_rd       = 32'hDEAD_BEEF;
      for (int k = 0; k < n; k++) begin
         #4;
         chk("rst_req_ready",    32'(rif.req_ready), 32'h0);
         chk("rst_scie_valid",   32'(scie_valid),    32'h0);
         chk("rst_scie_insn",    scie_insn,          32'h0);
         chk("rst_rsp_valid",    32'(rif.rsp_valid), 32'h0);
         chk("rst_rsp_data",     rif.rsp_data,       32'h0);
         chk("rst_lock_timeout", 32'(lock_timeout),  32'h0);
         chk("rst_state",        32'(dbg_state),     32'h0);
         @(negedge clock);
      end
      rif.req_valid = '0;
      reset = 1'b1;
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic [1:0] valid;
      logic [1:0] lock;
      logic [6:0] op0;
      logic [6:0] op1;
      logic [1:0] exp_ready;
      logic [1:0] exp_rsp;
   } vec_t;

   vec_t tbl [18];

   logic [N-1:0] a_ready, a_rsp;
   logic         a_to;
   logic [X-1:0] ri0, ri1;
   logic [N-1:0] rv, rl;

   initial begin
      rif.req_valid = '0; rif.req_lock = '0;
      rif.req_insn = '0; rif.req_rs1 = '0; rif.req_rs2 = '0;
      scie_rd = '0;
      model_reset();

      // round robin 0,1,0,1
      tbl[0]  = '{2'b11, 2'b00, 7'h0B, 7'h0B, 2'b01, 2'b00};
      tbl[1]  = '{2'b11, 2'b00, 7'h0B, 7'h0B, 2'b10, 2'b00};
      tbl[2]  = '{2'b11, 2'b00, 7'h0B, 7'h0B, 2'b01, 2'b00};
      tbl[3]  = '{2'b11, 2'b00, 7'h0B, 7'h0B, 2'b10, 2'b00};
      // req0 alone read, result two cycles later
      tbl[4]  = '{2'b01, 2'b00, 7'h5B, 7'h0B, 2'b01, 2'b00};
      tbl[5]  = '{2'b00, 2'b00, 7'h0B, 7'h0B, 2'b00, 2'b00};
      tbl[6]  = '{2'b00, 2'b00, 7'h0B, 7'h0B, 2'b00, 2'b01};
      // move pointer back to req0
      tbl[7]  = '{2'b10, 2'b00, 7'h0B, 7'h0B, 2'b10, 2'b00};
      // locked sequence 0x0B,0x2B,0x5B with req1 waiting
      tbl[8]  = '{2'b11, 2'b01, 7'h0B, 7'h0B, 2'b01, 2'b00};
      tbl[9]  = '{2'b11, 2'b01, 7'h2B, 7'h0B, 2'b01, 2'b00};
      tbl[10] = '{2'b11, 2'b00, 7'h5B, 7'h0B, 2'b01, 2'b00};
      tbl[11] = '{2'b11, 2'b00, 7'h0B, 7'h0B, 2'b10, 2'b00};
      tbl[12] = '{2'b00, 2'b00, 7'h0B, 7'h0B, 2'b00, 2'b01};
      // req1 read then req0 read back to back
      tbl[13] = '{2'b10, 2'b00, 7'h0B, 7'h5B, 2'b10, 2'b00};
      tbl[14] = '{2'b01, 2'b00, 7'h5B, 7'h0B, 2'b01, 2'b00};
      tbl[15] = '{2'b00, 2'b00, 7'h0B, 7'h0B, 2'b00, 2'b10};
      tbl[16] = '{2'b00, 2'b00, 7'h0B, 7'h0B, 2'b00, 2'b01};
      tbl[17] = '{2'b00, 2'b00, 7'h0B, 7'h0B, 2'b00, 2'b00};

      do_reset(2);

      for (int i = 0; i < 18; i++) begin
         ri0 = {25'h0, tbl[i].op0};
         ri1 = {25'h0, tbl[i].op1};
         cycle(tbl[i].valid, tbl[i].lock, ri0, ri1, a_ready, a_rsp, a_to);
         chk($sformatf("tbl%0d_ready", i), 32'(a_ready), 32'(tbl[i].exp_ready));
         chk($sformatf("tbl%0d_rsp", i),   32'(a_rsp),   32'(tbl[i].exp_rsp));
      end

      // lock watchdog: req0 locks then goes idle while req1 waits
      cycle(2'b01, 2'b01, 32'h0B, 32'h0B, a_ready, a_rsp, a_to);
      chk("wd_lock_grant", 32'(a_ready), 32'h1);
      for (int i = 0; i < TO; i++) begin
         cycle(2'b10, 2'b00, 32'h0B, 32'h0B, a_ready, a_rsp, a_to);
         chk("wd_idle_ready", 32'(a_ready), 32'h0);
         chk("wd_idle_pulse", 32'(a_to),    32'h0);
      end
      cycle(2'b10, 2'b00, 32'h0B, 32'h0B, a_ready, a_rsp, a_to);
      chk("wd_pulse",        32'(a_to),    32'h1);
      chk("wd_req1_granted", 32'(a_ready), 32'h2);
      cycle(2'b00, 2'b00, 32'h0B, 32'h0B, a_ready, a_rsp, a_to);
      chk("wd_pulse_end",    32'(a_to),    32'h0);

      // reset with two reads in flight
      cycle(2'b01, 2'b00, 32'h5B, 32'h0B, a_ready, a_rsp, a_to);
      cycle(2'b10, 2'b00, 32'h0B, 32'h5B, a_ready, a_rsp, a_to);
      do_reset(1);
      for (int i = 0; i < 3; i++) begin
         cycle(2'b00, 2'b00, 32'h0B, 32'h0B, a_ready, a_rsp, a_to);
         chk("rst_no_rsp", 32'(a_rsp), 32'h0);
      end
      cycle(2'b11, 2'b00, 32'h0B, 32'h0B, a_ready, a_rsp, a_to);
      chk("rst_req0_first", 32'(a_ready), 32'h1);

      // randomized traffic against the model; sparse phase exercises the watchdog
      for (int i = 0; i < 1200; i++) begin
         if (i < 600) begin
            rv = N'($urandom_range(3, 0));
            rl = N'($urandom_range(3, 0)) & N'($urandom_range(3, 0));
         end else begin
            rv = '0;
            for (int r = 0; r < N; r++) rv[r] = ($urandom_range(7, 0) == 0);
            rl = N'($urandom_range(3, 0)) | N'($urandom_range(3, 0));
         end
         ri0 = $urandom; ri1 = $urandom;
         if ($urandom_range(1, 0) == 1) ri0[6:0] = 7'h5B;
         if ($urandom_range(1, 0) == 1) ri1[6:0] = 7'h5B;
         cycle(rv, rl, ri0, ri1, a_ready, a_rsp, a_to);
      end

      for (int i = 0; i < LAT + 1; i++) begin
         cycle(2'b00, 2'b00, 32'h0, 32'h0, a_ready, a_rsp, a_to);
      end
      chk("drain_outstanding", 32'(exp_q.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
